alu_serial_driver: RTL and testbench
====================================

# alu_serial_driver

Bit-serial ALU sequencer that drives the team's external 1-bit ALU slice over 32 consecutive cycles to produce a full 32-bit result. It sits between the datapath and the slice. It decodes the 4-bit ALU control into slice controls, feeds operand bits LSB-first, and carries the slice's carry-out back in as carry-in. It assembles the result, derives the flags, and reports completion with a start/done handshake. This is the low-area alternative to the 32-slice ripple ALU for the multi-cycle CPU.

## Interface
- WIDTH, 32: operand width; fixed at 32 for this release.
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  asynchronous reset, active-low.
- start_i  in  1  request; sampled only in IDLE or DONE.
- src1_i  in  32  operand A.
- src2_i  in  32  operand B.
- ctrl_i  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse when result_o and the flags become valid.
- result_o  out  32  result; held until the next accepted start.
- zero_o  out  1  result_o == 0.
- cout_o  out  1  carry out of bit 31 (ADD/SUB/SLT), else 0.
- overflow_o  out  1  signed overflow (ADD/SUB/SLT), else 0.
- equal_o  out  1  src1 == src2, the AND of slice_equal_out over all 32 bits.
- slice_src1, slice_src2, slice_cin, slice_less  out  1 each  bit-level stimulus to the slice.
- slice_A_invert, slice_B_invert  out  1 each  slice operand inversion.
- slice_operation  out  2  slice op select.
- slice_result, slice_cout, slice_equal_out, slice_set_out  in  1 each  slice responses; the slice is combinational. slice_set_out is unused.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start_i=1 latches src1_i, src2_i and ctrl_i, clears the bit index and the equal accumulator, then goes to RUN.
  - RUN: lasts exactly 32 cycles (bit index k = 0..31). At k=31 it goes to DONE.
  - DONE: done_o=1 for this cycle only. Next state is RUN if start_i=1 (back-to-back, new operands latched), otherwise IDLE.
- Decode, as (A_invert, B_invert, operation, initial cin):
  - AND (0,0,00,0); OR (0,0,01,0); ADD (0,0,10,0); SUB (0,1,10,1); SLT (0,1,10,1); NOR (1,1,00,0); NAND (1,1,01,0).
  - SLT always drives slice op 10, never 11; the set bit is computed in this block.
- Illegal ctrl: the block still runs for 32 cycles with decode (0,0,00,0). result_o is forced to 0, and all flags are 0 except zero_o=1.
- In cycle k: slice_src1=A[k], slice_src2=B[k], slice_less=0. slice_cin is the initial cin when k=0, else the carry register. Controls are held constant for the whole RUN.
- At each RUN edge:
  - slice_result is shifted into the result shift register (MSB-in, LSB-first ordering, so after 32 shifts bit k sits at position k).
  - The carry register takes slice_cout.
  - The equal accumulator ANDs in slice_equal_out.
- At the k=31 edge:
  - cout_o = slice_cout.
  - overflow_o = cin31 XOR slice_cout, where cin31 is the slice_cin driven in cycle 31.
  - For SLT: result_o = {31'b0, sum31 XOR overflow}, while cout_o and overflow_o still report the subtraction.
  - zero_o is computed from the final result_o.
- Outside RUN, all slice_* outputs are 0.

## Timing
- Latency: with start accepted at edge T, the bits are driven in cycles T..T+31 after that edge. done_o and valid outputs appear in the cycle after edge T+32. That gives 33 cycles from start to done, and a back-to-back throughput of one op per 33 cycles.
- busy_o=1 exactly during the 32 RUN cycles.
- start_i during RUN is ignored and not queued.
- Reset (asynchronous, active-low) takes effect immediately, at any point including mid-RUN:
  - state returns to IDLE.
  - busy_o, done_o, result_o, zero_o, cout_o, overflow_o, equal_o and all slice_* outputs go to 0.
  - A partial result is discarded.
- After reset is released, the first start_i is sampled on the next rising edge.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done exactly 33 cycles after start.
- SUB 0x00000005 − 0x00000005 -> result 0, zero 1, cout 1, overflow 0, equal 1.
- SLT with src1=0x80000000, src2=0x00000001 -> result 1. Then, back-to-back with start held through DONE, SLT 0x00000001 vs 0x80000000 -> result 0, with no idle cycle between the two ops.
- NOR 0x0F0F0000 with 0x00FF00FF -> 0xF000FF00. NAND 0xFFFFFFFF with 0x0000FFFF -> 0xFFFF0000. Check slice_A_invert = slice_B_invert = 1 during RUN.
- Assert rst_i low at RUN cycle 10 of an ADD -> all outputs 0 immediately. A new start after release yields the correct result with no leftover carry.
- Illegal ctrl 1111 -> done after 33 cycles, result 0, zero 1; start_i pulses during RUN are ignored.

Source files
------------

// File: rtl/alu_serial_driver.sv
// alu_serial_driver: bit-serial ALU sequencer for an external combinational
// 1-bit ALU slice. Streams operand bits LSB-first over WIDTH cycles, feeds the
// slice carry-out back in as carry-in, and collects the result and the flags.
module alu_serial_driver #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             equal_o,
  output logic             slice_src1,
  output logic             slice_src2,
  output logic             slice_cin,
  output logic             slice_less,
  output logic             slice_A_invert,
  output logic             slice_B_invert,
  output logic [1:0]       slice_operation,
  input  logic             slice_result,
  input  logic             slice_cout,
  input  logic             slice_equal_out,
  input  logic             slice_set_out
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    CTRL_AND  = 4'b0000,
    CTRL_OR   = 4'b0001,
    CTRL_ADD  = 4'b0010,
    CTRL_SUB  = 4'b0110,
    CTRL_SLT  = 4'b0111,
    CTRL_NOR  = 4'b1100,
    CTRL_NAND = 4'b1101
  } ctrl_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             eq_acc;

  // Latched decode, held constant for the whole run
  logic       a_inv;
  logic       b_inv;
  logic [1:0] op;
  logic       cin0;
  logic       arith;
  logic       slt;
  logic       legal;

  // Decode of the incoming control word
  logic       dec_a_inv;
  logic       dec_b_inv;
  logic [1:0] dec_op;
  logic       dec_cin;
  logic       dec_arith;
  logic       dec_slt;
  logic       dec_legal;

  logic             running;
  logic             load;
  logic             last;
  logic             ovf;
  logic [WIDTH-1:0] raw_result;
  logic [WIDTH-1:0] final_result;

  // The set output of the slice is not needed: SLT is resolved here
  logic unused_set;
  assign unused_set = slice_set_out;

  assign running = (state == RUN);
  assign load    = start_i && ((state == IDLE) || (state == DONE));
  assign last    = running && (idx == LAST);

  // Translate the 4-bit ALU control into slice controls
  always_comb begin
    dec_a_inv = 1'b0;
    dec_b_inv = 1'b0;
    dec_op    = 2'b00;
    dec_cin   = 1'b0;
    dec_arith = 1'b0;
    dec_slt   = 1'b0;
    dec_legal = 1'b1;
    case (ctrl_i)
      CTRL_AND:  ;
      CTRL_OR:   dec_op = 2'b01;
      CTRL_ADD: begin
        dec_op    = 2'b10;
        dec_arith = 1'b1;
      end
      CTRL_SUB: begin
        dec_b_inv = 1'b1;
        dec_op    = 2'b10;
        dec_cin   = 1'b1;
        dec_arith = 1'b1;
      end
      CTRL_SLT: begin
        dec_b_inv = 1'b1;
        dec_op    = 2'b10;
        dec_cin   = 1'b1;
        dec_arith = 1'b1;
        dec_slt   = 1'b1;
      end
      CTRL_NOR: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
      end
      CTRL_NAND: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
        dec_op    = 2'b01;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Slice stimulus: live only during RUN, forced low otherwise
  always_comb begin
    slice_src1      = running & a_sh[0];
    slice_src2      = running & b_sh[0];
    slice_cin       = running & ((idx == '0) ? cin0 : carry);
    slice_less      = 1'b0;
    slice_A_invert  = running & a_inv;
    slice_B_invert  = running & b_inv;
    slice_operation = running ? op : 2'b00;
  end

  // Final result assembled from the shift register plus the last slice bit
  always_comb begin
    raw_result = {slice_result, res_sh[WIDTH-1:1]};
    ovf        = slice_cin ^ slice_cout;
    if (!legal) begin
      final_result = '0;
    end else if (slt) begin
      final_result = {{(WIDTH-1){1'b0}}, slice_result ^ ovf};
    end else begin
      final_result = raw_result;
    end
  end

  // Sequencer FSM with registered handshake, result and flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      eq_acc     <= 1'b0;
      a_inv      <= 1'b0;
      b_inv      <= 1'b0;
      op         <= 2'b00;
      cin0       <= 1'b0;
      arith      <= 1'b0;
      slt        <= 1'b0;
      legal      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      equal_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (load) begin
        state  <= RUN;
        busy_o <= 1'b1;
        a_sh   <= src1_i;
        b_sh   <= src2_i;
        res_sh <= '0;
        idx    <= '0;
        carry  <= 1'b0;
        eq_acc <= 1'b1;
        a_inv  <= dec_a_inv;
        b_inv  <= dec_b_inv;
        op     <= dec_op;
        cin0   <= dec_cin;
        arith  <= dec_arith;
        slt    <= dec_slt;
        legal  <= dec_legal;
      end else begin
        case (state)
          RUN: begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= raw_result;
            carry  <= slice_cout;
            eq_acc <= eq_acc & slice_equal_out;
            idx    <= idx + 1'b1;
            if (last) begin
              state      <= DONE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              result_o   <= final_result;
              zero_o     <= (final_result == '0);
              cout_o     <= legal & arith & slice_cout;
              overflow_o <= legal & arith & ovf;
              equal_o    <= legal & eq_acc & slice_equal_out;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_driver.sv
// Directed bench for alu_serial_driver with a behavioural 1-bit ALU slice.
module tb_alu_serial_driver;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ctrl;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        ovf;
  logic        equal;
  logic        s_src1, s_src2, s_cin, s_less, s_ainv, s_binv;
  logic [1:0]  s_op;
  logic        s_result, s_cout, s_eq, s_set;

  int total = 0;
  int bad   = 0;
  int cyc;

  alu_serial_driver #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src1_i(src1), .src2_i(src2), .ctrl_i(ctrl),
    .busy_o(busy), .done_o(done), .result_o(result), .zero_o(zero),
    .cout_o(cout), .overflow_o(ovf), .equal_o(equal),
    .slice_src1(s_src1), .slice_src2(s_src2), .slice_cin(s_cin),
    .slice_less(s_less), .slice_A_invert(s_ainv), .slice_B_invert(s_binv),
    .slice_operation(s_op),
    .slice_result(s_result), .slice_cout(s_cout),
    .slice_equal_out(s_eq), .slice_set_out(s_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external 1-bit ALU slice
  logic a_bit, b_bit, sum_bit;
  always_comb begin
    a_bit   = s_src1 ^ s_ainv;
    b_bit   = s_src2 ^ s_binv;
    sum_bit = a_bit ^ b_bit ^ s_cin;
    case (s_op)
      2'b00:   s_result = a_bit & b_bit;
      2'b01:   s_result = a_bit | b_bit;
      2'b10:   s_result = sum_bit;
      default: s_result = s_less;
    endcase
    s_cout = (a_bit & b_bit) | (a_bit & s_cin) | (b_bit & s_cin);
    s_eq   = ~(s_src1 ^ s_src2);
    s_set  = sum_bit;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input bit hold);
    @(negedge clk);
    src1  = a;
    src2  = b;
    ctrl  = c;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Counts edges from the accepting edge (=1) until done is seen, bounded
  task automatic wait_done(input bit pulse, output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (pulse) start = (cycles == 6 || cycles == 21);
    end
  endtask

  task automatic check_flags(input string tag, input logic [31:0] r,
                             input logic z, input logic c, input logic v, input logic e);
    check({tag, ".result"}, result, r);
    check({tag, ".flags"}, {28'd0, zero, cout, ovf, equal}, {28'd0, z, c, v, e});
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    ctrl  = '0;
    @(negedge clk);
    check("reset.outs", {busy, done, zero, cout, ovf, equal, result}, '0);
    check("reset.slice", {24'd0, s_src1, s_src2, s_cin, s_less, s_ainv, s_binv, s_op}, '0);
    rst = 1'b1;

    // ADD with signed overflow
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
    check("add.busy", {31'd0, busy}, 32'd1);
    wait_done(1'b0, cyc);
    check("add.latency", cyc, 33);
    check_flags("add", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("add.done_pulse", {30'd0, done, busy}, 32'd0);

    // SUB equal operands
    start_op(32'h0000_0005, 32'h0000_0005, 4'b0110, 1'b0);
    check("sub.slice_ctl", {28'd0, s_ainv, s_binv, s_op}, {28'd0, 1'b0, 1'b1, 2'b10});
    wait_done(1'b0, cyc);
    check("sub.latency", cyc, 33);
    check_flags("sub", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);

    // SLT back-to-back with start held through DONE
    start_op(32'h8000_0000, 32'h0000_0001, 4'b0111, 1'b1);
    wait_done(1'b0, cyc);
    check("slt1.latency", cyc, 33);
    check_flags("slt1", 32'h1, 1'b0, 1'b1, 1'b1, 1'b0);
    src1 = 32'h0000_0001;
    src2 = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    check("slt2.no_idle", {30'd0, busy, done}, 32'd2);
    wait_done(1'b0, cyc);
    check("slt2.latency", cyc, 33);
    check_flags("slt2", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // NOR
    start_op(32'h0F0F_0000, 32'h00FF_00FF, 4'b1100, 1'b0);
    check("nor.inv", {30'd0, s_ainv, s_binv}, 32'd3);
    check("nor.op", {30'd0, s_op}, 32'd0);
    wait_done(1'b0, cyc);
    check_flags("nor", 32'hF000_FF00, 1'b0, 1'b0, 1'b0, 1'b0);

    // NAND
    start_op(32'hFFFF_FFFF, 32'h0000_FFFF, 4'b1101, 1'b0);
    check("nand.inv", {30'd0, s_ainv, s_binv}, 32'd3);
    check("nand.op", {30'd0, s_op}, 32'd1);
    wait_done(1'b0, cyc);
    check_flags("nand", 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("idle.slice", {24'd0, s_src1, s_src2, s_cin, s_less, s_ainv, s_binv, s_op}, '0);

    // Reset in the middle of an ADD that is carrying
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.outs", {busy, done, zero, cout, ovf, equal, result}, '0);
    check("midrst.slice", {24'd0, s_src1, s_src2, s_cin, s_less, s_ainv, s_binv, s_op}, '0);
    @(negedge clk);
    rst = 1'b1;
    start_op(32'h1234_5678, 32'h1111_1111, 4'b0010, 1'b0);
    wait_done(1'b0, cyc);
    check("postrst.latency", cyc, 33);
    check_flags("postrst", 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal control with ignored start pulses during RUN
    start_op(32'h0000_0005, 32'h0000_0005, 4'b1111, 1'b0);
    wait_done(1'b1, cyc);
    start = 1'b0;
    check("illegal.latency", cyc, 33);
    check_flags("illegal", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("illegal.idle", {30'd0, busy, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
